// File: rtl/rv32i_types.sv
// Shared types for the common-data-bus arbiter.
//   ROB_IDX_W    : ROB index width carried in a broadcast result
//   SRC_W        : width of the winning-requester index on the CDB
//   req_idx_e    : functional-unit requester numbering
//   cdb_result_t : one result as queued per requester and broadcast on the CDB
package rv32i_types;

    localparam int ROB_IDX_W = 5;
    localparam int SRC_W     = 2;

    typedef enum logic [SRC_W-1:0] {
        REQ_ALU = 2'd0,
        REQ_MUL = 2'd1,
        REQ_BR  = 2'd2,
        REQ_MEM = 2'd3
    } req_idx_e;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [4:0]           rd_addr;
        logic [31:0]          data;
        logic                 regf_we;
    } cdb_result_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester-side and broadcast-side signals of the CDB arbiter.
//   req_valid/req_ready       : per-requester push handshake
//   req_rob_idx/rd_addr/data/
//   req_regf_we               : per-requester result payload
//   cdb_valid/cdb_src         : broadcast strobe and winning requester
//   cdb_rob_idx/rd_addr/data/
//   cdb_regf_we               : broadcast payload
// Modports: master = functional units / result consumers, slave = arbiter.
interface cdb_arbiter_if #(
    parameter int NUM_REQ       = 4,
    parameter int ROB_IDX_WIDTH = 5
);
    logic [NUM_REQ-1:0]                    req_valid;
    logic [NUM_REQ-1:0]                    req_ready;
    logic [NUM_REQ-1:0][ROB_IDX_WIDTH-1:0] req_rob_idx;
    logic [NUM_REQ-1:0][4:0]               req_rd_addr;
    logic [NUM_REQ-1:0][31:0]              req_data;
    logic [NUM_REQ-1:0]                    req_regf_we;

    logic                     cdb_valid;
    logic [1:0]               cdb_src;
    logic [ROB_IDX_WIDTH-1:0] cdb_rob_idx;
    logic [4:0]               cdb_rd_addr;
    logic [31:0]              cdb_data;
    logic                     cdb_regf_we;

    modport master (
        output req_valid, req_rob_idx, req_rd_addr, req_data, req_regf_we,
        input  req_ready,
        input  cdb_valid, cdb_src, cdb_rob_idx, cdb_rd_addr, cdb_data, cdb_regf_we
    );

    modport slave (
        input  req_valid, req_rob_idx, req_rd_addr, req_data, req_regf_we,
        output req_ready,
        output cdb_valid, cdb_src, cdb_rob_idx, cdb_rd_addr, cdb_data, cdb_regf_we
    );
endinterface

// File: rtl/cdb_result_fifo.sv
// Circular result queue for one functional unit.
//   clk, rst   : clock, asynchronous active-low reset
//   flush_i    : synchronous clear of all entries
//   push_i     : write data_i at the tail (ignored when full or flushing)
//   pop_i      : retire the head entry (ignored when empty or flushing)
//   head_o     : oldest entry, valid whenever nonempty_o
//   ready_o    : room for one more entry, from registered count only
//   nonempty_o : at least one entry queued
import rv32i_types::*;

module cdb_result_fifo #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        push_i,
    input  cdb_result_t data_i,
    input  logic        pop_i,
    output cdb_result_t head_o,
    output logic        ready_o,
    output logic        nonempty_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    cdb_result_t        mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    // Explicit wrap so non-power-of-two depths stay in range.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ready_o    = (count_q < CNT_W'(DEPTH));
    assign nonempty_o = (count_q != '0);
    assign head_o     = mem_q[head_q];

    assign do_push = push_i & ready_o & ~flush_i;
    assign do_pop  = pop_i & nonempty_o & ~flush_i;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) tail_d = wrap_inc(tail_q);
            if (do_pop)  head_d = wrap_inc(head_q);
            // Push and pop together leave the count unchanged.
            if (do_push && !do_pop)      count_d = count_q + 1'b1;
            else if (do_pop && !do_push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage is never reset; occupancy alone says what is live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[tail_q] <= data_i;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one result queue per functional unit, a
// round-robin pick of one non-empty queue per cycle, and a registered
// broadcast of the winner's oldest result.
//   clk   : clock
//   rst   : asynchronous active-low reset
//   flush : synchronous squash of queued and in-flight results
//   bus   : requester handshakes/payloads and the CDB broadcast (slave side)
import rv32i_types::*;

module cdb_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DEPTH         = 2,
    parameter int ROB_IDX_WIDTH = ROB_IDX_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    cdb_result_t        push_data [NUM_REQ];
    cdb_result_t        head_data [NUM_REQ];
    logic [NUM_REQ-1:0] push, pop, nonempty, ready;

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   cand;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_vld;

    logic               cdb_valid_q, cdb_valid_d;
    logic [SRC_W-1:0]   cdb_src_q, cdb_src_d;
    cdb_result_t        cdb_res_q, cdb_res_d;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
        assign push_data[i] = '{
            rob_idx: ROB_IDX_W'(bus.req_rob_idx[i]),
            rd_addr: bus.req_rd_addr[i],
            data:    bus.req_data[i],
            regf_we: bus.req_regf_we[i]
        };
        assign push[i] = bus.req_valid[i] & ready[i] & ~flush;
        assign pop[i]  = grant_vld & ~flush & (grant_idx == PTR_W'(i));

        cdb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .flush_i    (flush),
            .push_i     (push[i]),
            .data_i     (push_data[i]),
            .pop_i      (pop[i]),
            .head_o     (head_data[i]),
            .ready_o    (ready[i]),
            .nonempty_o (nonempty[i])
        );
    end

    assign bus.req_ready = ready;

    // Round-robin search from rr_ptr: scanning offsets high-to-low lets the
    // smallest offset (closest to rr_ptr) overwrite any later candidate.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (nonempty[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        cdb_src_d   = '0;
        cdb_res_d   = '0;
        if (flush) begin
            rr_ptr_d = '0;
        end else if (grant_vld) begin
            rr_ptr_d    = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            cdb_valid_d = 1'b1;
            cdb_src_d   = SRC_W'(grant_idx);
            cdb_res_d   = head_data[grant_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_src_q   <= '0;
            cdb_res_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_src_q   <= cdb_src_d;
            cdb_res_q   <= cdb_res_d;
        end
    end

    assign bus.cdb_valid   = cdb_valid_q;
    assign bus.cdb_src     = cdb_src_q;
    assign bus.cdb_rob_idx = ROB_IDX_WIDTH'(cdb_res_q.rob_idx);
    assign bus.cdb_rd_addr = cdb_res_q.rd_addr;
    assign bus.cdb_data    = cdb_res_q.data;
    assign bus.cdb_regf_we = cdb_res_q.regf_we;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (NUM_REQ=4, DEPTH=2): a vector table of
// per-cycle pushes with expected post-edge outputs, plus hand sequences for
// the single-push latency case and a mid-stream reset.
module tb_cdb_arbiter;
    import rv32i_types::*;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic flush = 1'b0;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_REQ(4), .ROB_IDX_WIDTH(5)) bus ();

    cdb_arbiter #(.NUM_REQ(4), .DEPTH(2), .ROB_IDX_WIDTH(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0]      vld;
        logic [3:0][4:0] rob;
        logic            fl;
        logic [3:0]      rdy;
        logic            cv;
        logic [1:0]      src;
        logic [4:0]      erob;
    } vec_t;

    localparam int NV = 32;
    vec_t vecs [NV];

    function automatic vec_t mk(logic [3:0] vld, logic [4:0] r3, logic [4:0] r2,
                                logic [4:0] r1, logic [4:0] r0, logic fl,
                                logic [3:0] rdy, logic cv, logic [1:0] src,
                                logic [4:0] erob);
        vec_t v;
        v.vld = vld; v.rob = {r3, r2, r1, r0}; v.fl = fl;
        v.rdy = rdy; v.cv = cv; v.src = src; v.erob = erob;
        return v;
    endfunction

    // Payload derived from the ROB index so one field pins the whole result.
    function automatic logic [4:0] rd_of(logic [4:0] r);
        return ~r;
    endfunction
    function automatic logic [31:0] data_of(logic [4:0] r);
        return 32'hC0DE_0000 | {27'd0, r};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid   = '0;
        bus.req_rob_idx = '0;
        bus.req_rd_addr = '0;
        bus.req_data    = '0;
        bus.req_regf_we = '0;
        flush           = 1'b0;
    endtask

    task automatic drive(vec_t v);
        for (int i = 0; i < 4; i++) begin
            bus.req_valid[i]   = v.vld[i];
            bus.req_rob_idx[i] = v.rob[i];
            bus.req_rd_addr[i] = rd_of(v.rob[i]);
            bus.req_data[i]    = data_of(v.rob[i]);
            bus.req_regf_we[i] = v.rob[i][0];
        end
        flush = v.fl;
    endtask

    task automatic check_out(string tag, logic cv, logic [1:0] src,
                             logic [4:0] rob, logic [3:0] rdy);
        chk({tag, " cdb_valid"}, 32'(bus.cdb_valid), 32'(cv));
        chk({tag, " cdb_src"},   32'(bus.cdb_src),   cv ? 32'(src) : 32'd0);
        chk({tag, " rob_idx"},   32'(bus.cdb_rob_idx), cv ? 32'(rob) : 32'd0);
        chk({tag, " rd_addr"},   32'(bus.cdb_rd_addr), cv ? 32'(rd_of(rob)) : 32'd0);
        chk({tag, " data"},      bus.cdb_data,       cv ? data_of(rob) : 32'd0);
        chk({tag, " regf_we"},   32'(bus.cdb_regf_we), cv ? 32'(rob[0]) : 32'd0);
        chk({tag, " req_ready"}, 32'(bus.req_ready), 32'(rdy));
    endtask

    initial begin
        // Fields: vld, rob3..rob0, flush | ready, cdb_valid, src, rob
        // All four push at rr_ptr=0: strict 0,1,2,3 order.
        vecs[0]  = mk(4'b1111, 5'd4, 5'd3, 5'd2, 5'd1, 0, 4'b1111, 0, 2'd0, 5'd0);
        vecs[1]  = mk(4'b0000, 0, 0, 0, 0,             0, 4'b1111, 1, 2'd0, 5'd1);
        vecs[2]  = mk(4'b0000, 0, 0, 0, 0,             0, 4'b1111, 1, 2'd1, 5'd2);
        vecs[3]  = mk(4'b0000, 0, 0, 0, 0,             0, 4'b1111, 1, 2'd2, 5'd3);
        vecs[4]  = mk(4'b0000, 0, 0, 0, 0,             0, 4'b1111, 1, 2'd3, 5'd4);
        vecs[5]  = mk(4'b0000, 0, 0, 0, 0,             0, 4'b1111, 0, 2'd0, 5'd0);
        // alu and mul push continuously: grants alternate 0,1,0,1.
        vecs[6]  = mk(4'b0011, 0, 0, 5'd6,  5'd5,      0, 4'b1111, 0, 2'd0, 5'd0);
        vecs[7]  = mk(4'b0011, 0, 0, 5'd8,  5'd7,      0, 4'b1101, 1, 2'd0, 5'd5);
        vecs[8]  = mk(4'b0011, 0, 0, 5'd10, 5'd9,      0, 4'b1110, 1, 2'd1, 5'd6);
        vecs[9]  = mk(4'b0010, 0, 0, 5'd10, 0,         0, 4'b1101, 1, 2'd0, 5'd7);
        vecs[10] = mk(4'b0000, 0, 0, 0, 0,             0, 4'b1111, 1, 2'd1, 5'd8);
        vecs[11] = mk(4'b0000, 0, 0, 0, 0,             0, 4'b1111, 1, 2'd0, 5'd9);
        vecs[12] = mk(4'b0000, 0, 0, 0, 0,             0, 4'b1111, 1, 2'd1, 5'd10);
        vecs[13] = mk(4'b0000, 0, 0, 0, 0,             0, 4'b1111, 0, 2'd0, 5'd0);
        // mem pushes three times while others are busy; third is held.
        vecs[14] = mk(4'b1111, 5'd11, 5'd14, 5'd13, 5'd12, 0, 4'b1111, 0, 2'd0, 5'd0);
        vecs[15] = mk(4'b1000, 5'd15, 0, 0, 0,         0, 4'b0111, 1, 2'd2, 5'd14);
        vecs[16] = mk(4'b1000, 5'd16, 0, 0, 0,         0, 4'b1111, 1, 2'd3, 5'd11);
        vecs[17] = mk(4'b1000, 5'd16, 0, 0, 0,         0, 4'b0111, 1, 2'd0, 5'd12);
        vecs[18] = mk(4'b0000, 0, 0, 0, 0,             0, 4'b0111, 1, 2'd1, 5'd13);
        vecs[19] = mk(4'b0000, 0, 0, 0, 0,             0, 4'b1111, 1, 2'd3, 5'd15);
        vecs[20] = mk(4'b0000, 0, 0, 0, 0,             0, 4'b1111, 1, 2'd3, 5'd16);
        vecs[21] = mk(4'b0000, 0, 0, 0, 0,             0, 4'b1111, 0, 2'd0, 5'd0);
        // Five entries queued, then flush with a dropped push.
        vecs[22] = mk(4'b1111, 5'd23, 5'd22, 5'd21, 5'd20, 0, 4'b1111, 0, 2'd0, 5'd0);
        vecs[23] = mk(4'b0010, 0, 0, 5'd25, 0,         0, 4'b1101, 1, 2'd0, 5'd20);
        vecs[24] = mk(4'b0101, 0, 5'd27, 0, 5'd26,     0, 4'b1011, 1, 2'd1, 5'd21);
        vecs[25] = mk(4'b1000, 5'd28, 0, 0, 0,         1, 4'b1111, 0, 2'd0, 5'd0);
        vecs[26] = mk(4'b0000, 0, 0, 0, 0,             0, 4'b1111, 0, 2'd0, 5'd0);
        vecs[27] = mk(4'b0000, 0, 0, 0, 0,             0, 4'b1111, 0, 2'd0, 5'd0);
        vecs[28] = mk(4'b0000, 0, 0, 0, 0,             0, 4'b1111, 0, 2'd0, 5'd0);
        vecs[29] = mk(4'b0100, 0, 5'd29, 0, 0,         0, 4'b1111, 0, 2'd0, 5'd0);
        vecs[30] = mk(4'b0000, 0, 0, 0, 0,             0, 4'b1111, 1, 2'd2, 5'd29);
        vecs[31] = mk(4'b0000, 0, 0, 0, 0,             0, 4'b1111, 0, 2'd0, 5'd0);

        clear_inputs();
        repeat (2) step();
        check_out("reset", 1'b0, 2'd0, 5'd0, 4'b1111);
        rst = 1'b1;

        // Single alu push in cycle 1 -> broadcast in cycle 3, then idle.
        bus.req_valid[0]   = 1'b1;
        bus.req_rob_idx[0] = 5'd3;
        bus.req_rd_addr[0] = 5'd5;
        bus.req_data[0]    = 32'h0000_00AA;
        bus.req_regf_we[0] = 1'b1;
        step();
        clear_inputs();
        chk("single c2 cdb_valid", 32'(bus.cdb_valid), 32'd0);
        step();
        chk("single c3 cdb_valid", 32'(bus.cdb_valid),   32'd1);
        chk("single c3 cdb_src",   32'(bus.cdb_src),     32'd0);
        chk("single c3 rob_idx",   32'(bus.cdb_rob_idx), 32'd3);
        chk("single c3 rd_addr",   32'(bus.cdb_rd_addr), 32'd5);
        chk("single c3 data",      bus.cdb_data,         32'h0000_00AA);
        chk("single c3 regf_we",   32'(bus.cdb_regf_we), 32'd1);
        step();
        chk("single c4 cdb_valid", 32'(bus.cdb_valid), 32'd0);

        // Empty flush to bring rr_ptr back to 0 for the table.
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_out("flush0", 1'b0, 2'd0, 5'd0, 4'b1111);

        for (int k = 0; k < NV; k++) begin
            drive(vecs[k]);
            step();
            check_out($sformatf("vec%0d", k), vecs[k].cv, vecs[k].src,
                      vecs[k].erob, vecs[k].rdy);
        end
        clear_inputs();

        // Mid-stream reset: queued rob 31 must never appear.
        bus.req_valid       = 4'b0011;
        bus.req_rob_idx[0]  = 5'd30;
        bus.req_rd_addr[0]  = rd_of(5'd30);
        bus.req_data[0]     = data_of(5'd30);
        bus.req_regf_we[0]  = 1'b0;
        bus.req_rob_idx[1]  = 5'd31;
        bus.req_rd_addr[1]  = rd_of(5'd31);
        bus.req_data[1]     = data_of(5'd31);
        bus.req_regf_we[1]  = 1'b1;
        step();
        clear_inputs();
        check_out("prerst0", 1'b0, 2'd0, 5'd0, 4'b1111);
        step();
        check_out("prerst1", 1'b1, 2'd0, 5'd30, 4'b1111);
        #2;
        rst = 1'b0;
        #1;
        check_out("inrst", 1'b0, 2'd0, 5'd0, 4'b1111);
        #4;
        rst = 1'b1;
        bus.req_valid[2]   = 1'b1;
        bus.req_rob_idx[2] = 5'd7;
        bus.req_rd_addr[2] = rd_of(5'd7);
        bus.req_data[2]    = data_of(5'd7);
        bus.req_regf_we[2] = 1'b1;
        step();
        clear_inputs();
        check_out("postrst0", 1'b0, 2'd0, 5'd0, 4'b1111);
        step();
        check_out("postrst1", 1'b1, 2'd2, 5'd7, 4'b1111);
        step();
        check_out("postrst2", 1'b0, 2'd0, 5'd0, 4'b1111);
        step();
        check_out("postrst3", 1'b0, 2'd0, 5'd0, 4'b1111);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of functional-unit requesters (0=alu, 1=mul, 2=br, 3=mem).
REQ-002 Parameter DEPTH, default 2, entries per requester result queue.
REQ-003 Parameter ROB_IDX_WIDTH, default 5, ROB index width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously with clk.
REQ-006 flush  input  1  synchronous squash of all queued and in-flight results.
REQ-007 req_valid  input  NUM_REQ  per-requester result valid.
REQ-008 req_ready  output  NUM_REQ  per-requester queue can accept.
REQ-009 req_rob_idx  input  NUM_REQ x ROB_IDX_WIDTH  per-requester result ROB index.
REQ-010 req_rd_addr  input  NUM_REQ x 5  per-requester destination register.
REQ-011 req_data  input  NUM_REQ x 32  per-requester result data.
REQ-012 req_regf_we  input  NUM_REQ  per-requester register-write flag.
REQ-013 cdb_valid  output  1  broadcast valid this cycle.
REQ-014 cdb_src  output  2  index of the winning requester.
REQ-015 cdb_rob_idx, cdb_rd_addr, cdb_data, cdb_regf_we  output  ROB_IDX_WIDTH/5/32/1  broadcast payload.

Function
REQ-016 Each requester owns a circular FIFO of DEPTH entries with head pointer, tail pointer and count.
REQ-017 req_ready[i] = (count[i] < DEPTH), from registered state only; no same-cycle pop bypass.
REQ-018 Push on req_valid[i] && req_ready[i] && !flush; payload is written at the tail and the tail wraps modulo DEPTH.
REQ-019 Each cycle the arbiter selects one non-empty FIFO round-robin, starting the search at rr_ptr and wrapping modulo NUM_REQ.
REQ-020 The winner's head pops into the output register; cdb_* outputs are registered and appear the cycle after selection.
REQ-021 After a grant, rr_ptr = (winner+1) mod NUM_REQ; with no grant, rr_ptr holds and cdb_valid = 0 on the next cycle.
REQ-022 Simultaneous push and pop on the same FIFO both take effect and the count is unchanged.
REQ-023 An uncontended result accepted in cycle t is broadcast with cdb_valid = 1 in cycle t+2.
REQ-024 Fairness: a non-empty FIFO is granted within NUM_REQ cycles.
REQ-025 Payload order per requester is strictly FIFO; a single requester's results are never reordered.
REQ-026 flush: all counts and pointers clear, rr_ptr = 0, pushes in the flush cycle are dropped, and cdb_valid = 0 the next cycle.
REQ-027 The cdb_valid = 0 cycle's payload is don't-care but is driven to zero.

Reset
REQ-028 On rst low: all FIFO counts and pointers = 0, rr_ptr = 0, and all cdb_* outputs = 0.
REQ-029 After reset, req_ready = all ones.
REQ-030 Reset mid-operation discards every queued entry with no broadcast.
REQ-031 FIFO payload storage needs no reset.

Structure
REQ-032 The cdb_result_t payload struct (rob_idx, rd_addr, data, regf_we) and the requester index enum are defined in rv32i_types.
REQ-033 One sub-module, cdb_result_fifo (parameter DEPTH), is instantiated NUM_REQ times.
REQ-034 The round-robin selector stays inline in cdb_arbiter.

Verification
REQ-035 Single push: alu pushes rob 3, rd x5, data 0x0000_00AA in cycle 1 -> cdb_valid in cycle 3 with src 0, rob 3, rd 5, data 0xAA; idle afterwards.
REQ-036 All four push simultaneously with rr_ptr = 0 -> broadcasts in the order src 0, 1, 2, 3 on four consecutive cycles.
REQ-037 mem pushes three times back-to-back with no grants taken (others busy, DEPTH = 2) -> req_ready[3] drops after the 2nd push and the 3rd push is held until space frees.
REQ-038 mul continuously pushes while alu also has entries -> grants alternate 0, 1, 0, 1 and neither is starved beyond NUM_REQ cycles.
REQ-039 flush asserted with 5 entries queued -> cdb_valid = 0 the next cycle, all req_ready = 1, and none of the flushed rob indices ever broadcast.
REQ-040 rst pulled low mid-stream for a half cycle -> outputs zero immediately, and after release the first new push is broadcast 2 cycles later.
